// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial sequence detector.
//   Samples one serial bit per qualified clock. It pulses dout when the last
//   PAT_W bits equal the programmable pattern (MSB is the first bit received).
//   A saturating counter tracks the number of matches.
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-low reset
//   seq_valid - qualifies seq on this edge
//   seq       - serial data bit
//   ovl       - 1: overlapping detection, 0: non-overlapping
//   pat_load  - load pat_in into the pattern register (wins over seq_valid)
//   pat_in    - new pattern value
//   clr_cnt   - synchronous clear of the match counter (applied before increment)
//   dout      - registered one-cycle match pulse
//   match_cnt - saturating match count
//   cnt_sat   - high while match_cnt is all ones
module seq_detect_param #(
  parameter int unsigned            PAT_W   = 4,
  parameter logic [PAT_W-1:0]       PATTERN = 4'b1011,
  parameter int unsigned            CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seq_valid,
  input  logic             seq,
  input  logic             ovl,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             clr_cnt,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_q,  pat_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              dout_q, dout_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic              sat_q,  sat_d;

  logic [PAT_W-1:0]  nxt;
  logic              match;
  logic [CNT_W-1:0]  cnt_base;

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    dout_d = 1'b0;
    match  = 1'b0;
    nxt    = {hist_q[PAT_W-2:0], seq};

    if (pat_load) begin
      // New pattern: restart qualification; any bit sampled on this edge is dropped.
      pat_d  = pat_in;
      fill_d = '0;
    end else if (seq_valid) begin
      hist_d = nxt;
      match  = (nxt == pat_q) && (fill_q >= FILL_LAST);
      if (match) begin
        dout_d = 1'b1;
        // Overlap keeps the history as a usable suffix; non-overlap demands fresh bits.
        fill_d = ovl ? FILL_FULL : '0;
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end

    // Clear first, then a match may increment the cleared value.
    cnt_base = clr_cnt ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (match && (cnt_base != '1)) begin
      cnt_d = cnt_base + CNT_W'(1);
    end
    sat_d = (cnt_d == '1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      dout_q <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  assign dout      = dout_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: three instances (default 4-bit pattern,
// 2-bit saturating counter, 6-bit pattern) share the control inputs.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       seq_valid = 1'b0;
  logic       seq = 1'b0;
  logic       ovl = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in4 = 4'b0000;
  logic [5:0] pat_in6 = 6'b000000;
  logic       clr_cnt = 1'b0;

  logic       dout0, dout1, dout2;
  logic [7:0] cnt0, cnt2;
  logic [1:0] cnt1;
  logic       sat0, sat1, sat2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .seq_valid(seq_valid), .seq(seq), .ovl(ovl),
    .pat_load(pat_load), .pat_in(pat_in4), .clr_cnt(clr_cnt),
    .dout(dout0), .match_cnt(cnt0), .cnt_sat(sat0));

  seq_detect_param #(.PAT_W(4), .PATTERN(4'b0000), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .seq_valid(seq_valid), .seq(seq), .ovl(ovl),
    .pat_load(pat_load), .pat_in(pat_in4), .clr_cnt(clr_cnt),
    .dout(dout1), .match_cnt(cnt1), .cnt_sat(sat1));

  seq_detect_param #(.PAT_W(6), .PATTERN(6'b110100), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .seq_valid(seq_valid), .seq(seq), .ovl(ovl),
    .pat_load(pat_load), .pat_in(pat_in6), .clr_cnt(clr_cnt),
    .dout(dout2), .match_cnt(cnt2), .cnt_sat(sat2));

  typedef struct {
    logic       pl;
    logic [3:0] pin;
    logic       sv;
    logic       s;
    logic       ov;
    logic       clr;
    logic       e_dout;
    logic [7:0] e_cnt;
    logic       e_sat;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic pl, input logic [3:0] pin, input logic sv,
                     input logic s, input logic ov, input logic clr,
                     input logic e_dout, input logic [7:0] e_cnt);
    vec_t v;
    v.pl = pl; v.pin = pin; v.sv = sv; v.s = s; v.ov = ov; v.clr = clr;
    v.e_dout = e_dout; v.e_cnt = e_cnt; v.e_sat = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one bit with plain controls, wait through one rising edge.
  task automatic send(input logic sv, input logic s, input logic ov, input logic clr);
    pat_load = 1'b0; seq_valid = sv; seq = s; ovl = ov; clr_cnt = clr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    pat_load = 1'b0; seq_valid = 1'b0; seq = 1'b0; clr_cnt = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Overlap: 1,0,1,1,0,1,1 -> pulses on edges 4 and 7
    row(0,4'h0,1,1,1,0, 0,0); row(0,4'h0,1,0,1,0, 0,0); row(0,4'h0,1,1,1,0, 0,0);
    row(0,4'h0,1,1,1,0, 1,1); row(0,4'h0,1,0,1,0, 0,1); row(0,4'h0,1,1,1,0, 0,1);
    row(0,4'h0,1,1,1,0, 1,2);
    // Reload same pattern to restart qualification
    row(1,4'b1011,0,0,0,0, 0,2);
    // Non-overlap: same stream -> only edge 4; then 1,0,1,1 -> pulse
    row(0,4'h0,1,1,0,0, 0,2); row(0,4'h0,1,0,0,0, 0,2); row(0,4'h0,1,1,0,0, 0,2);
    row(0,4'h0,1,1,0,0, 1,3); row(0,4'h0,1,0,0,0, 0,3); row(0,4'h0,1,1,0,0, 0,3);
    row(0,4'h0,1,1,0,0, 0,3);
    row(0,4'h0,1,1,0,0, 0,3); row(0,4'h0,1,0,0,0, 0,3); row(0,4'h0,1,1,0,0, 0,3);
    row(0,4'h0,1,1,0,0, 1,4);
    // Gaps: 1,0,(3 idle with seq toggling),1,1 -> pulse on final edge
    row(0,4'h0,1,1,0,0, 0,4); row(0,4'h0,1,0,0,0, 0,4);
    row(0,4'h0,0,1,0,0, 0,4); row(0,4'h0,0,0,0,0, 0,4); row(0,4'h0,0,1,0,0, 0,4);
    row(0,4'h0,1,1,0,0, 0,4); row(0,4'h0,1,1,0,0, 1,5);
    // Load 0000 with a same-edge bit (ignored), then six zeros in overlap
    row(1,4'b0000,1,1,0,0, 0,5);
    row(0,4'h0,1,0,1,0, 0,5); row(0,4'h0,1,0,1,0, 0,5); row(0,4'h0,1,0,1,0, 0,5);
    row(0,4'h0,1,0,1,0, 1,6); row(0,4'h0,1,0,1,0, 1,7); row(0,4'h0,1,0,1,0, 1,8);
    // Load 1000 with seq=1 on the load edge; three zeros must not match
    row(1,4'b1000,1,1,1,0, 0,8);
    row(0,4'h0,1,0,1,0, 0,8); row(0,4'h0,1,0,1,0, 0,8); row(0,4'h0,1,0,1,0, 0,8);
    // 1,0,0,0 with clr on the matching edge -> count 1; then clr alone -> 0
    row(0,4'h0,1,1,1,0, 0,8); row(0,4'h0,1,0,1,0, 0,8); row(0,4'h0,1,0,1,0, 0,8);
    row(0,4'h0,1,0,1,1, 1,1);
    row(0,4'h0,0,0,1,1, 0,0);

    // Reset state
    rst = 1'b0;
    #3;
    check("reset_dout", 32'(dout0), 32'd0);
    check("reset_cnt",  32'(cnt0),  32'd0);
    check("reset_sat",  32'(sat0),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      pat_load = vecs[i].pl; pat_in4 = vecs[i].pin; seq_valid = vecs[i].sv;
      seq = vecs[i].s; ovl = vecs[i].ov; clr_cnt = vecs[i].clr;
      @(negedge clk);
      check($sformatf("vec%0d_dout", i), 32'(dout0), 32'(vecs[i].e_dout));
      check($sformatf("vec%0d_cnt", i),  32'(cnt0),  32'(vecs[i].e_cnt));
      check($sformatf("vec%0d_sat", i),  32'(sat0),  32'(vecs[i].e_sat));
    end

    // Async reset mid-cycle while dout is high and count nonzero
    pat_load = 1'b1; pat_in4 = 4'b1011; seq_valid = 1'b0; clr_cnt = 1'b0;
    @(negedge clk);
    send(1,1,1,0); send(1,0,1,0); send(1,1,1,0); send(1,1,1,0);
    check("pre_reset_dout", 32'(dout0), 32'd1);
    check("pre_reset_cnt",  32'(cnt0),  32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_reset_dout", 32'(dout0), 32'd0);
    check("async_reset_cnt",  32'(cnt0),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    // 1,0,1 then reset for one cycle, then 1: history lost, no pulse
    send(1,1,1,0); send(1,0,1,0); send(1,1,1,0);
    seq_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    send(1,1,1,0);
    check("hist_lost_dout", 32'(dout0), 32'd0);
    check("hist_lost_cnt",  32'(cnt0),  32'd0);

    // Saturation on the 2-bit counter instance (pattern 0000, overlap)
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      logic [1:0] ec;
      ec = (i < 4) ? 2'd0 : ((i - 3 >= 3) ? 2'd3 : 2'(i - 3));
      send(1,0,1,0);
      check($sformatf("sat_e%0d_dout", i), 32'(dout1), (i >= 4) ? 32'd1 : 32'd0);
      check($sformatf("sat_e%0d_cnt", i),  32'(cnt1),  32'(ec));
      check($sformatf("sat_e%0d_sat", i),  32'(sat1),  (ec == 2'd3) ? 32'd1 : 32'd0);
    end
    send(1,0,1,1);
    check("clr_match_cnt", 32'(cnt1), 32'd1);
    check("clr_match_sat", 32'(sat1), 32'd0);
    send(0,0,1,1);
    check("clr_idle_cnt", 32'(cnt1), 32'd0);
    check("clr_idle_sat", 32'(sat1), 32'd0);

    // 6-bit pattern 110100, non-overlap, stream repeated twice
    do_reset();
    begin
      logic [11:0] stream;
      stream = 12'b110100_110100;
      for (int i = 0; i < 12; i++) begin
        send(1, stream[11-i], 0, 0);
        check($sformatf("w6_e%0d_dout", i+1), 32'(dout2),
              (i == 5 || i == 11) ? 32'd1 : 32'd0);
      end
    end
    check("w6_cnt", 32'(cnt2), 32'd2);
    check("w6_sat", 32'(sat2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
